// File: rtl/a2d_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : a2d_scheduler                                                |
// | Description : Sequences two-transaction conversions on the shared ADC128S  |
// |               A2D. Channels rotate lft -> rght -> steer -> batt, with a    |
// |               battery-priority request served ahead of the rotation. Each  |
// |               12-bit result lands in its own holding register.             |
// |               Optional macro A2D_AVG_EN enables a two-tap smoothing filter |
// |               on every capture: (old + new + 1) >> 1.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module a2d_scheduler #(
   parameter logic [2:0] CH_LFT   = 3'd0,
   parameter logic [2:0] CH_RGHT  = 3'd4,
   parameter logic [2:0] CH_STEER = 3'd5,
   parameter logic [2:0] CH_BATT  = 3'd6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   input  logic        batt_req,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        cnv_cmplt,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TX1   = 3'd1,
      WAIT1 = 3'd2,
      GAP   = 3'd3,
      TX2   = 3'd4,
      WAIT2 = 3'd5,
      CMPLT = 3'd6
   } state_t;

   // Slot indices double as result-register selectors
   localparam logic [1:0] c_SLOT_LFT   = 2'd0;
   localparam logic [1:0] c_SLOT_RGHT  = 2'd1;
   localparam logic [1:0] c_SLOT_STEER = 2'd2;
   localparam logic [1:0] c_SLOT_BATT  = 2'd3;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_ptr;        // round-robin slot pointer
   logic        r_pend;       // one-deep pending trigger
   logic        r_batt_pend;  // battery-priority request outstanding
   logic [1:0]  r_sel;        // slot being converted
   logic        r_adv;        // pointer advances when this conversion completes
   logic [15:0] r_cmd;
   logic [11:0] r_lft;
   logic [11:0] r_rght;
   logic [11:0] r_steer;
   logic [11:0] r_batt;

   logic        w_start;
   logic        w_capture;
   logic [1:0]  w_sel;
   logic        w_adv;
   logic [2:0]  w_chnl;
   logic [11:0] w_result;
   logic        w_unused_rd;

   // The upper command/status bits of the received word carry no result
   assign w_unused_rd = ^rd_data[15:12];

   // Pick the slot for the next conversion: battery priority overrides rotation
   always_comb begin
      w_sel = r_ptr;
      w_adv = 1'b1;
      if (r_batt_pend) begin
         w_sel = c_SLOT_BATT;
         // Only move on when the priority grant coincides with the batt slot
         w_adv = (r_ptr == c_SLOT_BATT);
      end
   end

   // Map the selected slot onto its ADC channel address
   always_comb begin
      w_chnl = CH_LFT;
      case (w_sel)
         c_SLOT_LFT:   w_chnl = CH_LFT;
         c_SLOT_RGHT:  w_chnl = CH_RGHT;
         c_SLOT_STEER: w_chnl = CH_STEER;
         default:      w_chnl = CH_BATT;
      endcase
   end

`ifdef A2D_AVG_EN
   logic [11:0] w_old;
   logic [12:0] w_sum;

   // Two-tap smoothing: average the incoming sample with the held value
   always_comb begin
      w_old = r_lft;
      case (r_sel)
         c_SLOT_LFT:   w_old = r_lft;
         c_SLOT_RGHT:  w_old = r_rght;
         c_SLOT_STEER: w_old = r_steer;
         default:      w_old = r_batt;
      endcase
      w_sum    = {1'b0, w_old} + {1'b0, rd_data[11:0]} + 13'd1;
      w_result = w_sum[12:1];
   end
`else
   // Raw capture of the 12-bit conversion result
   always_comb begin
      w_result = rd_data[11:0];
   end
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and Moore outputs
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      wrt         = 1'b0;
      cnv_cmplt   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (nxt || r_pend) begin
               w_start     = 1'b1;
               w_state_nxt = TX1;
            end
         end
         TX1: begin
            wrt         = 1'b1;
            w_state_nxt = WAIT1;
         end
         WAIT1: begin
            if (done) w_state_nxt = GAP;
         end
         GAP: begin
            // Idle cycle lets SS_n deassert between the two transactions
            w_state_nxt = TX2;
         end
         TX2: begin
            wrt         = 1'b1;
            w_state_nxt = WAIT2;
         end
         WAIT2: begin
            if (done) begin
               w_capture   = 1'b1;
               w_state_nxt = CMPLT;
            end
         end
         CMPLT: begin
            cnv_cmplt   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Channel selection, command word, rotation pointer and request flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr       <= c_SLOT_LFT;
         r_pend      <= 1'b0;
         r_batt_pend <= 1'b0;
         r_sel       <= c_SLOT_LFT;
         r_adv       <= 1'b0;
         r_cmd       <= 16'h0000;
      end else begin
         if (w_start) begin
            r_sel <= w_sel;
            r_adv <= w_adv;
            r_cmd <= {2'b00, w_chnl, 11'h000};
         end

         if (w_start)                       r_pend <= 1'b0;
         else if (nxt && r_state != IDLE)   r_pend <= 1'b1;

         if (r_state == CMPLT && r_adv)     r_ptr <= r_ptr + 2'd1;

         // A request landing in the clearing cycle must not be lost
         if (batt_req)                                        r_batt_pend <= 1'b1;
         else if (r_state == CMPLT && r_sel == c_SLOT_BATT)   r_batt_pend <= 1'b0;
      end
   end

   // Per-channel result holding registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lft   <= 12'h000;
         r_rght  <= 12'h000;
         r_steer <= 12'h000;
         r_batt  <= 12'h000;
      end else if (w_capture) begin
         case (r_sel)
            c_SLOT_LFT:   r_lft   <= w_result;
            c_SLOT_RGHT:  r_rght  <= w_result;
            c_SLOT_STEER: r_steer <= w_result;
            default:      r_batt  <= w_result;
         endcase
      end
   end

   assign cmd       = r_cmd;
   assign lft_ld    = r_lft;
   assign rght_ld   = r_rght;
   assign steer_pot = r_steer;
   assign batt      = r_batt;

endmodule
`default_nettype wire

// File: tb/tb_a2d_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_a2d_scheduler                                             |
// | Description : Self-checking bench for a2d_scheduler with a timestamp-based |
// |               reference model, a simple SPI responder and directed tests.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_a2d_scheduler;

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        nxt        = 1'b0;
   logic        batt_req   = 1'b0;
   logic        resp_done  = 1'b0;
   logic        stray_done = 1'b0;
   logic [15:0] rd_data    = 16'hFFFF;
   logic        done;
   logic        wrt;
   logic [15:0] cmd;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic [11:0] steer_pot;
   logic [11:0] batt;
   logic        cnv_cmplt;
   logic        busy;

   assign done = resp_done | stray_done;

   a2d_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .nxt       (nxt),
      .batt_req  (batt_req),
      .wrt       (wrt),
      .cmd       (cmd),
      .done      (done),
      .rd_data   (rd_data),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .steer_pot (steer_pot),
      .batt      (batt),
      .cnv_cmplt (cnv_cmplt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // SPI responder: done arrives four cycles after each wrt
   logic [11:0] resp_val = 12'h000;
   logic        wrt_seen = 1'b0;
   int          resp_cnt = 0;

   always @(negedge clk) wrt_seen = wrt;

   always @(posedge clk) begin
      #1;
      resp_done = 1'b0;
      rd_data   = 16'hFFFF;
      if (rst) begin
         resp_cnt = 0;
      end else begin
         if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
               resp_done = 1'b1;
               rd_data   = {4'hA, resp_val};
            end
         end
         if (wrt_seen) resp_cnt = 3;
      end
   end

   // Scoreboard counters
   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int cnv_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: timed out waiting, got none expected event", name);
   endtask

   // Reference model: conversion milestones tracked as cycle timestamps
   logic        m_busy;
   logic        m_pend;
   logic        m_bpend;
   logic        m_await;
   logic        m_adv;
   int          m_ptr;
   int          m_slot;
   int          m_wrts;
   int          m_wrt_at;
   int          m_cmplt_at;
   logic [15:0] m_cmd;
   logic [11:0] m_reg [4];

   function automatic logic [2:0] ch_of(input int slot);
      case (slot)
         0:       return 3'd0;
         1:       return 3'd4;
         2:       return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   task automatic model_reset();
      m_busy     = 1'b0;
      m_pend     = 1'b0;
      m_bpend    = 1'b0;
      m_await    = 1'b0;
      m_adv      = 1'b0;
      m_ptr      = 0;
      m_slot     = 0;
      m_wrts     = 0;
      m_wrt_at   = -1;
      m_cmplt_at = -1;
      m_cmd      = 16'h0000;
      for (int i = 0; i < 4; i++) m_reg[i] = 12'h000;
   endtask

   task automatic model_step();
      int s;
      if (!m_busy) begin
         if (nxt || m_pend) begin
            m_pend = 1'b0;
            if (m_bpend) begin
               m_slot = 3;
               m_adv  = (m_ptr == 3);
            end else begin
               m_slot = m_ptr;
               m_adv  = 1'b1;
            end
            m_cmd    = {2'b00, ch_of(m_slot), 11'h000};
            m_busy   = 1'b1;
            m_wrt_at = cyc + 1;
            m_wrts   = 0;
            m_await  = 1'b0;
         end
      end else begin
         if (nxt) m_pend = 1'b1;
         if (cyc == m_wrt_at) begin
            m_wrts  = m_wrts + 1;
            m_await = 1'b1;
         end else if (m_await && done) begin
            m_await = 1'b0;
            if (m_wrts == 1) begin
               m_wrt_at = cyc + 2;
            end else begin
`ifdef A2D_AVG_EN
               s = (int'(m_reg[m_slot]) + int'(rd_data[11:0]) + 1) / 2;
`else
               s = int'(rd_data[11:0]);
`endif
               m_reg[m_slot] = s[11:0];
               m_cmplt_at    = cyc + 1;
            end
         end else if (cyc == m_cmplt_at) begin
            m_busy = 1'b0;
            if (m_adv) m_ptr = (m_ptr + 1) % 4;
            if (m_slot == 3) m_bpend = 1'b0;
         end
      end
      if (batt_req) m_bpend = 1'b1;
   endtask

   // Cycle-by-cycle comparison of every output against the model
   task automatic compare_loop();
      model_reset();
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (rst) model_reset();
         chk("wrt",       {31'd0, wrt},       {31'd0, (cyc == m_wrt_at)});
         chk("cnv_cmplt", {31'd0, cnv_cmplt}, {31'd0, (cyc == m_cmplt_at)});
         chk("busy",      {31'd0, busy},      {31'd0, m_busy});
         chk("cmd",       {16'd0, cmd},       {16'd0, m_cmd});
         chk("lft_ld",    {20'd0, lft_ld},    {20'd0, m_reg[0]});
         chk("rght_ld",   {20'd0, rght_ld},   {20'd0, m_reg[1]});
         chk("steer_pot", {20'd0, steer_pot}, {20'd0, m_reg[2]});
         chk("batt",      {20'd0, batt},      {20'd0, m_reg[3]});
         if (cnv_cmplt) cnv_count = cnv_count + 1;
         if (!rst) model_step();
      end
   endtask

   // Stimulus helpers; all drive points sit 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_nxt();
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
   endtask

   task automatic wait_cmplt(input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         @(negedge clk);
         if (cnv_cmplt) hit = 1'b1;
      end
      if (!hit) fail_timeout(name);
      tick();
   endtask

   task automatic wait_done(input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (done) hit = 1'b1;
      end
      if (!hit) fail_timeout(name);
   endtask

   task automatic wait_wrt(input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (wrt) hit = 1'b1;
      end
      if (!hit) fail_timeout(name);
   endtask

   logic [11:0] t1_val [4];
   logic [15:0] t1_cmd [4];

   initial begin
      int base;
      int gap;
      t1_val = '{12'h300, 12'h2F0, 12'h800, 12'hC00};
      t1_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};

      fork
         compare_loop();
      join_none

      // Reset state
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wrt",  {31'd0, wrt},  32'd0);
      chk("rst_cmd",  {16'd0, cmd},  32'h0000);
      chk("rst_lft",  {20'd0, lft_ld}, 32'h000);
      chk("rst_batt", {20'd0, batt},   32'h000);

      // Full rotation lft -> rght -> steer -> batt
      base = cnv_count;
      for (int i = 0; i < 4; i++) begin
         resp_val = t1_val[i];
         pulse_nxt();
         wait_cmplt("rot_cmplt");
         chk("rot_cmd", {16'd0, cmd}, {16'd0, t1_cmd[i]});
      end
`ifndef A2D_AVG_EN
      chk("rot_lft",   {20'd0, lft_ld},    32'h300);
      chk("rot_rght",  {20'd0, rght_ld},   32'h2F0);
      chk("rot_steer", {20'd0, steer_pot}, 32'h800);
      chk("rot_batt",  {20'd0, batt},      32'hC00);
`endif
      chk("rot_pulses", cnv_count - base, 32'd4);

      // Battery priority with the pointer at lft, then rotation resumes at lft
      batt_req = 1'b1;
      tick();
      batt_req = 1'b0;
      resp_val = 12'h123;
      pulse_nxt();
      wait_cmplt("prio_cmplt");
      chk("prio_cmd", {16'd0, cmd}, 32'h3000);
`ifndef A2D_AVG_EN
      chk("prio_batt", {20'd0, batt}, 32'h123);
`endif
      resp_val = 12'h456;
      pulse_nxt();
      wait_cmplt("after_prio_cmplt");
      chk("after_prio_cmd", {16'd0, cmd}, 32'h0000);
`ifndef A2D_AVG_EN
      chk("after_prio_lft", {20'd0, lft_ld}, 32'h456);
`endif

      // Three triggers during WAIT1 collapse into one pending conversion
      base     = cnv_count;
      resp_val = 12'h0AB;
      pulse_nxt();
      tick();
      nxt = 1'b1;
      tick(); tick(); tick();
      nxt = 1'b0;
      wait_cmplt("pend_first");
      resp_val = 12'h0CD;
      gap = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         gap = gap + 1;
         if (wrt) break;
      end
      chk("pend_restart_gap", gap, 32'd2);
      tick();
      wait_cmplt("pend_second");
      for (int i = 0; i < 20; i++) tick();
      chk("pend_pulses", cnv_count - base, 32'd2);
      chk("pend_cmd", {16'd0, cmd}, 32'h2800);
`ifndef A2D_AVG_EN
      chk("pend_rght",  {20'd0, rght_ld},   32'h0AB);
      chk("pend_steer", {20'd0, steer_pot}, 32'h0CD);
`endif

      // Stray done in IDLE and in GAP
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      tick();
      chk("stray_idle_busy", {31'd0, busy}, 32'd0);
      resp_val = 12'h777;
      pulse_nxt();
      wait_done("stray_first_done");
      tick();
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      wait_cmplt("stray_cmplt");
`ifndef A2D_AVG_EN
      chk("stray_batt", {20'd0, batt}, 32'h777);
`endif

      // Reset during WAIT2
      resp_val = 12'h999;
      pulse_nxt();
      wait_done("rst_first_done");
      wait_wrt("rst_second_wrt");
      tick();
      tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("mid_rst_busy",  {31'd0, busy},      32'd0);
      chk("mid_rst_wrt",   {31'd0, wrt},       32'd0);
      chk("mid_rst_cmd",   {16'd0, cmd},       32'h0000);
      chk("mid_rst_lft",   {20'd0, lft_ld},    32'h000);
      chk("mid_rst_rght",  {20'd0, rght_ld},   32'h000);
      chk("mid_rst_steer", {20'd0, steer_pot}, 32'h000);
      chk("mid_rst_batt",  {20'd0, batt},      32'h000);
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      tick();
      chk("post_rst_done_busy", {31'd0, busy}, 32'd0);
      resp_val = 12'h321;
      pulse_nxt();
      wait_cmplt("post_rst_cmplt");
      chk("post_rst_cmd", {16'd0, cmd}, 32'h0000);
`ifndef A2D_AVG_EN
      chk("post_rst_lft", {20'd0, lft_ld}, 32'h321);
`endif

`ifdef A2D_AVG_EN
      // Smoothing filter: 0x400 then 0x401 on lft
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      resp_val = 12'h400;
      pulse_nxt();
      wait_cmplt("avg_first");
      chk("avg_first_lft", {20'd0, lft_ld}, 32'h200);
      resp_val = 12'h000;
      for (int i = 0; i < 3; i++) begin
         pulse_nxt();
         wait_cmplt("avg_rotate");
      end
      resp_val = 12'h401;
      pulse_nxt();
      wait_cmplt("avg_second");
      chk("avg_second_lft", {20'd0, lft_ld}, 32'h301);
`endif

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
